// File: rtl/di_fifo_terminal.sv
// di_fifo_terminal: host-bus FIFO terminal; writes to register 0 push 16-bit words, reads pop them.
// It also provides a count register, a flush control and sticky overflow/underflow flags.
module di_fifo_terminal #(
    parameter logic [15:0] TERM_ADDR  = 16'h0003,
    parameter int          DEPTH_LOG2 = 6
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic [15:0] di_term_addr,
    input  logic [31:0] di_reg_addr,
    input  logic [31:0] di_len,
    input  logic        di_write_mode,
    input  logic        di_write,
    input  logic [15:0] di_reg_datai,
    input  logic        di_read_mode,
    input  logic        di_read_req,
    input  logic        di_read,
    output logic [15:0] di_reg_datao,
    output logic        di_read_rdy,
    output logic        di_write_rdy,
    output logic [15:0] di_transfer_status
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, FETCH, VALID} rd_state_t;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [15:0]           dout_q;
    rd_state_t             state;
    logic ovf, udf, live, wmode_q, rmode_q, rd_data, rdy_q;
    logic sel, at_data, full, empty, wr, rreq, rd, push, pop, flush, clr, ovf_set, udf_set;
    logic unused_ok;

    assign unused_ok = ^{di_len, di_reg_addr[31:2]};
    assign sel     = di_term_addr == TERM_ADDR;
    assign at_data = di_reg_addr[1:0] == 2'd0;
    // count never exceeds DEPTH, so its MSB alone marks the full state
    assign full    = count[DEPTH_LOG2];
    assign empty   = count == '0;
    // live masks strobes during the first cycle after reset is released
    assign wr      = live && sel && di_write;
    assign rreq    = live && sel && di_read_req && di_read_mode;
    assign rd      = live && sel && di_read;
    assign pop     = rd && rdy_q && rd_data && !empty;
    assign flush   = wr && di_reg_addr[1:0] == 2'd2 && di_reg_datai[0];
    assign push    = wr && at_data && (!full || pop) && !flush;
    assign ovf_set = wr && at_data && full && !pop;
    assign udf_set = rreq && at_data && empty;
    assign clr     = flush || (sel && ((di_write_mode && !wmode_q) || (di_read_mode && !rmode_q)));

    assign di_reg_datao       = dout_q;
    assign di_read_rdy        = rdy_q;
    assign di_write_rdy       = !(sel && at_data && full);
    assign di_transfer_status = sel ? {14'b0, udf, ovf} : 16'h0000;

    always_ff @(posedge ifclk) begin
        if (push) mem[wr_ptr] <= di_reg_datai;
    end

    always_ff @(posedge ifclk) begin
        if (!resetb) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            live    <= 1'b0;
            wmode_q <= 1'b0;
            rmode_q <= 1'b0;
            rd_data <= 1'b0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
            state   <= IDLE;
        end else begin
            live    <= 1'b1;
            wmode_q <= di_write_mode;
            rmode_q <= di_read_mode;
            ovf     <= ovf_set || (ovf && !clr);
            udf     <= udf_set || (udf && !clr);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
            end
            // an empty data fetch leaves dout_q alone so no word is fabricated
            if (!di_read_mode) begin
                state <= IDLE;
                rdy_q <= 1'b0;
            end else if (rreq) begin
                state   <= FETCH;
                rd_data <= at_data;
                rdy_q   <= !at_data || !empty;
                if (!at_data || !empty)
                    dout_q <= at_data ? mem[rd_ptr] :
                              di_reg_addr[1:0] == 2'd1 ? 16'(count) :
                              di_reg_addr[1:0] == 2'd2 ? 16'h0000 : {14'b0, udf, ovf};
            end else if (rd && rdy_q) begin
                state <= IDLE;
                rdy_q <= 1'b0;
            end else if (state == FETCH) begin
                state <= rdy_q ? VALID : IDLE;
            end
        end
    end
endmodule

// File: tb/tb_di_fifo_terminal.sv
// tb_di_fifo_terminal: scoreboard bench for di_fifo_terminal against a queue-based reference model.
module tb_di_fifo_terminal;
    logic        ifclk = 1'b0;
    logic        resetb;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_write_mode, di_write, di_read_mode, di_read_req, di_read;
    logic [15:0] di_reg_datai, di_reg_datao, di_transfer_status;
    logic        di_read_rdy, di_write_rdy;

    di_fifo_terminal dut (
        .ifclk(ifclk), .resetb(resetb), .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
        .di_len(di_len), .di_write_mode(di_write_mode), .di_write(di_write),
        .di_reg_datai(di_reg_datai), .di_read_mode(di_read_mode), .di_read_req(di_read_req),
        .di_read(di_read), .di_reg_datao(di_reg_datao), .di_read_rdy(di_read_rdy),
        .di_write_rdy(di_write_rdy), .di_transfer_status(di_transfer_status)
    );

    always #5 ifclk = ~ifclk;

    typedef struct {string n; logic [15:0] v;} exp_t;
    exp_t        sb[$];
    logic [15:0] model[$];
    logic        m_ovf, m_udf;
    int          total = 0, bad = 0;

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge ifclk) begin
        if (di_read && di_read_rdy) begin
            if (sb.size() == 0) check("unexpected_read", di_reg_datao, 16'hxxxx);
            else begin
                exp_t e;
                e = sb.pop_front();
                check(e.n, di_reg_datao, e.v);
            end
        end
    end

    task automatic tick();
        @(posedge ifclk);
        #1;
    endtask

    task automatic model_clear();
        model.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic write_word(input logic [1:0] a, input logic [15:0] d);
        di_reg_addr = {30'd0, a};
        di_reg_datai = d;
        di_write = 1'b1;
        tick();
        di_write = 1'b0;
        if (a == 2'd0) begin
            if (model.size() < 64) model.push_back(d);
            else m_ovf = 1'b1;
        end else if (a == 2'd2 && d[0]) model_clear();
    endtask

    task automatic check_status(input string n);
        check(n, di_transfer_status, {14'b0, m_udf, m_ovf});
    endtask

    task automatic do_read(input logic [1:0] a, input string n);
        logic [15:0] e;
        di_reg_addr = {30'd0, a};
        if (a == 2'd0 && model.size() == 0) begin
            di_read_req = 1'b1;
            tick();
            di_read_req = 1'b0;
            m_udf = 1'b1;
            check({n, "_rdy_empty"}, {15'd0, di_read_rdy}, 16'd0);
            tick();
            check({n, "_rdy_empty2"}, {15'd0, di_read_rdy}, 16'd0);
            return;
        end
        e = a == 2'd0 ? model[0] : a == 2'd1 ? 16'(model.size()) : a == 2'd2 ? 16'h0 : {14'b0, m_udf, m_ovf};
        sb.push_back('{n, e});
        di_read_req = 1'b1;
        tick();
        di_read_req = 1'b0;
        for (int i = 0; i < 8 && !di_read_rdy; i++) tick();
        if (!di_read_rdy) begin
            check({n, "_rdy_timeout"}, 16'd0, 16'd1);
            void'(sb.pop_back());
            return;
        end
        di_read = 1'b1;
        tick();
        di_read = 1'b0;
        if (a == 2'd0) void'(model.pop_front());
    endtask

    task automatic pop_push(input logic [15:0] d);
        di_reg_addr = 32'd0;
        sb.push_back('{"pop_push", model[0]});
        di_read_req = 1'b1;
        tick();
        di_read_req = 1'b0;
        check("pop_push_rdy", {15'd0, di_read_rdy}, 16'd1);
        di_read = 1'b1;
        di_write = 1'b1;
        di_reg_datai = d;
        tick();
        di_read = 1'b0;
        di_write = 1'b0;
        void'(model.pop_front());
        model.push_back(d);
    endtask

    initial begin
        resetb = 1'b0;
        di_term_addr = 16'h0003;
        di_reg_addr = '0;
        di_len = 32'd128;
        {di_write_mode, di_write, di_read_mode, di_read_req, di_read} = '0;
        di_reg_datai = '0;
        model_clear();
        repeat (3) tick();
        check("rst_datao", di_reg_datao, 16'h0);
        check("rst_read_rdy", {15'd0, di_read_rdy}, 16'd0);
        check("rst_write_rdy", {15'd0, di_write_rdy}, 16'd1);
        check("rst_status", di_transfer_status, 16'h0);
        // a write in the release cycle must be ignored
        resetb = 1'b1;
        di_write = 1'b1;
        di_reg_datai = 16'hDEAD;
        tick();
        di_write = 1'b0;
        di_write_mode = 1'b1;
        di_read_mode = 1'b1;
        repeat (2) tick();
        do_read(2'd1, "count_after_release");

        for (int i = 1; i <= 4; i++) write_word(2'd0, 16'(i * 16'h1111));
        for (int i = 0; i < 4; i++) do_read(2'd0, "basic_data");
        do_read(2'd1, "basic_count");
        check_status("basic_status");

        for (int i = 0; i < 64; i++) write_word(2'd0, 16'($urandom));
        check("full_write_rdy", {15'd0, di_write_rdy}, 16'd0);
        write_word(2'd0, 16'hBEEF);
        check("ovf_status", di_transfer_status, 16'h0001);
        check_status("ovf_status_model");
        do_read(2'd1, "full_count");
        di_reg_addr = 32'd1;
        #1 check("full_write_rdy_addr1", {15'd0, di_write_rdy}, 16'd1);
        do_read(2'd3, "flags_reg");
        for (int i = 0; i < 3; i++) pop_push(16'hA000 + 16'(i));
        do_read(2'd1, "pop_push_count");
        write_word(2'd2, 16'h0001);
        do_read(2'd1, "flush_count");
        check("flush_status", di_transfer_status, 16'h0000);

        do_read(2'd0, "empty_read");
        check("udf_status", di_transfer_status, 16'h0002);
        di_read_mode = 1'b0;
        tick();
        di_read_mode = 1'b1;
        tick();
        m_udf = 1'b0;
        check_status("mode_edge_clear");

        for (int i = 0; i < 60; i++) write_word(2'd0, 16'h5000 + 16'(i));
        for (int i = 0; i < 60; i++) do_read(2'd0, "pre_wrap");
        for (int i = 0; i < 10; i++) begin
            write_word(2'd0, 16'h7700 + 16'(i));
            do_read(2'd0, "wrap_data");
        end
        do_read(2'd1, "wrap_count");

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: write_word(2'd0, 16'($urandom));
                4, 5, 6: do_read(2'd0, "rand_data");
                7: do_read(2'd1, "rand_count");
                8: do_read(2'd3, "rand_flags");
                default: if ($urandom_range(0, 3) == 0) write_word(2'd2, 16'h0001);
                         else check_status("rand_status");
            endcase
        end

        di_term_addr = 16'h0005;
        di_reg_addr = 32'd0;
        di_write = 1'b1;
        di_reg_datai = 16'h1234;
        tick();
        di_write = 1'b0;
        check("unsel_status", di_transfer_status, 16'h0000);
        di_term_addr = 16'h0003;
        do_read(2'd1, "unsel_count");

        write_word(2'd2, 16'h0001);
        for (int i = 0; i < 5; i++) write_word(2'd0, 16'h0C00 + 16'(i));
        di_reg_addr = 32'd0;
        di_read_req = 1'b1;
        tick();
        di_read_req = 1'b0;
        check("midread_rdy", {15'd0, di_read_rdy}, 16'd1);
        resetb = 1'b0;
        tick();
        model_clear();
        check("rst_mid_read_rdy", {15'd0, di_read_rdy}, 16'd0);
        check("rst_mid_write_rdy", {15'd0, di_write_rdy}, 16'd1);
        check("rst_mid_status", di_transfer_status, 16'h0);
        resetb = 1'b1;
        repeat (2) tick();
        do_read(2'd1, "rst_mid_count");

        repeat (3) tick();
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
